mem_tp_fifo: RTL

MEM_TP_FIFO -- requirements
Module: mem_tp_fifo

---
 rtl/mem_tp_fifo.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mem_tp_fifo.sv
// FIFO over an external two-port RAM, with a 2-entry output buffer that hides the read latency.
// Optional high-water mark: define MEM_TP_FIFO_MAXLVL_EN.
module mem_tp_fifo #(
    parameter     MEM_TYPE      = "auto",
    parameter int MEM_DATAWIDTH = 128,
    parameter int MEM_ADDRWIDTH = 14
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [MEM_DATAWIDTH-1:0]       s_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [MEM_DATAWIDTH-1:0]       m_data,
    output logic [MEM_ADDRWIDTH:0]         level,
    output logic [MEM_ADDRWIDTH:0]         max_level,
    output logic                           ena,
    output logic [(MEM_DATAWIDTH+7)/8-1:0] wea,
    output logic [MEM_ADDRWIDTH-1:0]       addra,
    output logic [MEM_DATAWIDTH-1:0]       dina,
    output logic                           enb,
    output logic [MEM_ADDRWIDTH-1:0]       addrb,
    input  logic [MEM_DATAWIDTH-1:0]       doutb
);

    localparam int AW = MEM_ADDRWIDTH;
    localparam int DW = MEM_DATAWIDTH;
    localparam int WE = (MEM_DATAWIDTH+7)/8;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   ram_cnt;
    logic          rif;
    logic [1:0]    obuf_cnt;
    logic [1:0]    obuf_cnt_n;
    logic [DW-1:0] ob0;
    logic [DW-1:0] ob1;
    logic [DW-1:0] ob0_n;
    logic [DW-1:0] ob1_n;
    logic [2:0]    occ;
    logic          push;
    logic          pop;
    logic          rd;

    // level never exceeds DEPTH, so its MSB alone flags "full"
    assign s_ready = reset && !level[AW];
    assign m_valid = reset && (obuf_cnt != 2'd0);
    assign m_data  = ob0;

    assign push = s_valid && s_ready;
    assign pop  = m_valid && m_ready;

    // slots the output buffer will need once in-flight data lands
    assign occ = {1'b0, obuf_cnt} + {2'b00, rif} - {2'b00, pop};
    assign rd  = reset && (ram_cnt != '0) && (occ < 3'd2);

    assign ena   = push;
    assign wea   = {WE{push}};
    assign addra = wr_ptr;
    assign dina  = s_data;
    assign enb   = rd;
    assign addrb = rd_ptr;

    always_comb begin
        ob0_n      = ob0;
        ob1_n      = ob1;
        obuf_cnt_n = obuf_cnt;
        case ({rif, pop})
            2'b11: begin
                if (obuf_cnt == 2'd1) begin
                    ob0_n = doutb;
                end else begin
                    ob0_n = ob1;
                    ob1_n = doutb;
                end
            end
            2'b10: begin
                if (obuf_cnt == 2'd0)
                    ob0_n = doutb;
                else
                    ob1_n = doutb;
                obuf_cnt_n = obuf_cnt + 2'd1;
            end
            2'b01: begin
                ob0_n      = ob1;
                obuf_cnt_n = obuf_cnt - 2'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            rif      <= 1'b0;
            obuf_cnt <= 2'd0;
            level    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, rd})
                2'b10:   ram_cnt <= ram_cnt + (AW+1)'(1);
                2'b01:   ram_cnt <= ram_cnt - (AW+1)'(1);
                default: ;
            endcase
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: ;
            endcase
            rif      <= rd;
            obuf_cnt <= obuf_cnt_n;
        end
    end

    // payload registers need no reset; obuf_cnt qualifies them
    always_ff @(posedge clk) begin
        ob0 <= ob0_n;
        ob1 <= ob1_n;
    end

`ifdef MEM_TP_FIFO_MAXLVL_EN
    logic [AW:0] max_q;

    always_ff @(posedge clk) begin
        if (!reset)
            max_q <= '0;
        else if (level > max_q)
            max_q <= level;
    end

    assign max_level = max_q;
`else
    assign max_level = '0;
`endif

endmodule
